exu_dispatch: RTL and testbench
===============================

// Module: exu_dispatch
// PURPOSE
//  Dispatch controller between the decode stage and the execution units (ALU, BJP, MULDIV, AGU).
//  It takes one decoded instruction per cycle over a valid/ready handshake and routes it to the unit selected by i_grp.
//  It stalls on RAW/WAW hazards against outstanding long-latency writes (MULDIV, loads).
//  It tracks those writes in an in-order outstanding-instruction FIFO (OITF) that the writeback stage retires.
// PARAMETERS
//  OITF_DEPTH   2   outstanding long-latency entries; power of 2, >=2
//  PTR_W        1   log2(OITF_DEPTH)
// PORTS
//  clk            in   1                   core clock, all state on rising edge
//  rst_n          in   1                   synchronous reset, active low
//  i_valid        in   1                   decoded instruction valid
//  i_ready        out  1                   instruction accepted this cycle
//  i_grp          in   `DECINFO_GRP_WIDTH  group (`DECINFO_GRP_ALU/BJP/MULDIV/AGU)
//  i_load         in   1                   AGU op is a load
//  i_illegal      in   1                   decoder illegal flag
//  i_rs1en/i_rs2en/i_rdwen  in  1 each     register use enables
//  i_rs1idx/i_rs2idx/i_rdidx in `RFIDX_WIDTH each  register indices
//  i_flush        in   1                   pipeline flush; suppresses dispatch this cycle
//  o_alu_valid/i_alu_ready  out/in 1       ALU handshake
//  o_bjp_valid/i_bjp_ready  out/in 1       BJP handshake
//  o_mdv_valid/i_mdv_ready  out/in 1       MULDIV handshake
//  o_agu_valid/i_agu_ready  out/in 1       AGU handshake
//  o_disp_ptr     out  PTR_W               OITF slot allocated to the current long op
//  i_ret_valid    in   1                   writeback retires the oldest OITF entry
//  o_oitf_empty   out  1                   no outstanding long ops
//  o_illegal_evt  out  1                   pulse: illegal instruction consumed
//  o_oitf_err     out  1                   sticky: retire while empty
//  o_stall_cnt    out  32                  saturating count of hazard/full stall cycles
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): rd_ptr=wr_ptr=0, all entry valids=0, o_oitf_err=0, o_stall_cnt=0.
//   During reset every *_valid, i_ready and o_illegal_evt is 0.
//  Dispatch is combinational in the same cycle; no internal instruction buffer.
//  long   = (grp==MULDIV) | (grp==AGU & i_load); only long ops with i_rdwen allocate an OITF entry.
//  hazard = any valid OITF entry whose rdidx equals an enabled source (RAW) or rd when i_rdwen (WAW).
//   x0 is compared like any other register.
//   The entry retiring this cycle still counts as a hazard (no bypass).
//  block = i_flush | hazard | (long & i_rdwen & full).
//  o_X_valid = i_valid & ~i_illegal & ~block & (i_grp==X). Exactly one unit valid at a time.
//  i_ready = o_X_valid & i_X_ready for the selected unit,
//   or (i_valid & i_illegal & ~i_flush): illegal instructions are consumed without dispatch.
//  o_illegal_evt = i_valid & i_illegal & ~i_flush. An illegal instruction never allocates.
//  Alloc on (o_mdv|o_agu load)_valid & ready & i_rdwen:
//   entry[wr_ptr] <= {1,rdidx}; wr_ptr++ (wraps mod OITF_DEPTH).
//   o_disp_ptr = wr_ptr (valid only while a long op is offered).
//  Retire on i_ret_valid & ~empty: entry[rd_ptr].valid <= 0; rd_ptr++ (wraps).
//   Retire while empty: no pointer change, o_oitf_err <= 1 until reset.
//  Same-cycle alloc and retire is allowed and occupancy is unchanged.
//   When full, alloc is blocked that cycle even if a retire occurs.
//  full = occupancy==OITF_DEPTH; empty = occupancy==0. Occupancy is tracked with an extra wrap bit per pointer.
//  o_stall_cnt++ each cycle with i_valid & ~i_illegal & ~i_flush & block; saturates at 32'hFFFF_FFFF.
//  i_flush does not clear the OITF; outstanding writes still retire normally.
//  A valid may drop without ready (upstream flush); no state is changed.
// TESTING
//  1. Reset, then ALU add rd=x5 with i_alu_ready=1: o_alu_valid=1, i_ready=1, OITF unchanged, o_oitf_empty=1.
//  2. MULDIV rd=x3 accepted, then ALU rs1=x3: ALU stalls and o_stall_cnt increments each cycle.
//     Retire pulse -> ALU dispatches the cycle after the retire.
//  3. Two loads (rd=x1,x2) accepted: o_disp_ptr 0 then 1. A third load stalls (full).
//     Retire + new alloc in the same cycle -> blocked. Next cycle: load allocates slot 0 (wrap).
//  4. i_illegal=1, i_valid=1: i_ready=1, o_illegal_evt=1 for one cycle, no unit valid, no allocation.
//  5. Retire while empty: o_oitf_err=1 and stays 1. Pointers unchanged. Cleared only by rst_n=0.
//  6. Assert rst_n=0 with 2 entries pending: next cycle o_oitf_empty=1, o_stall_cnt=0, all valids 0.

Source files
------------

// File: rtl/exu_dispatch.sv
// Dispatch controller between decode and the execution units. It blocks on hazards
// against outstanding long-latency writes, which are tracked in an in-order OITF.
module exu_dispatch #(
  parameter int OITF_DEPTH = 2,
  parameter int PTR_W      = 1,
  parameter int GRP_W      = 2,
  parameter int RFIDX_W    = 5,
  parameter logic [GRP_W-1:0] GRP_ALU    = 2'd0,
  parameter logic [GRP_W-1:0] GRP_BJP    = 2'd1,
  parameter logic [GRP_W-1:0] GRP_MULDIV = 2'd2,
  parameter logic [GRP_W-1:0] GRP_AGU    = 2'd3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [GRP_W-1:0]   i_grp,
  input  logic               i_load,
  input  logic               i_illegal,
  input  logic               i_rs1en,
  input  logic               i_rs2en,
  input  logic               i_rdwen,
  input  logic [RFIDX_W-1:0] i_rs1idx,
  input  logic [RFIDX_W-1:0] i_rs2idx,
  input  logic [RFIDX_W-1:0] i_rdidx,
  input  logic               i_flush,
  output logic               o_alu_valid,
  input  logic               i_alu_ready,
  output logic               o_bjp_valid,
  input  logic               i_bjp_ready,
  output logic               o_mdv_valid,
  input  logic               i_mdv_ready,
  output logic               o_agu_valid,
  input  logic               i_agu_ready,
  output logic [PTR_W-1:0]   o_disp_ptr,
  input  logic               i_ret_valid,
  output logic               o_oitf_empty,
  output logic               o_illegal_evt,
  output logic               o_oitf_err,
  output logic [31:0]        o_stall_cnt
);

  logic [OITF_DEPTH-1:0] ent_vld_r;
  logic [RFIDX_W-1:0]    ent_idx_r [OITF_DEPTH];
  logic [PTR_W:0]        wr_ptr_r;
  logic [PTR_W:0]        rd_ptr_r;

  logic empty_s, full_s, long_s, hazard_s, block_s, disp_ok_s;
  logic alloc_s, retire_s, stall_inc_s;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign long_s  = (i_grp == GRP_MULDIV) | ((i_grp == GRP_AGU) & i_load);

  // RAW/WAW match against every pending entry; the retiring one is not bypassed.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (ent_vld_r[i] && ((i_rs1en && (ent_idx_r[i] == i_rs1idx)) ||
                           (i_rs2en && (ent_idx_r[i] == i_rs2idx)) ||
                           (i_rdwen && (ent_idx_r[i] == i_rdidx)))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  assign block_s   = i_flush | hazard_s | (long_s & i_rdwen & full_s);
  assign disp_ok_s = rst_n & i_valid & ~i_illegal & ~block_s;

  assign o_alu_valid = disp_ok_s & (i_grp == GRP_ALU);
  assign o_bjp_valid = disp_ok_s & (i_grp == GRP_BJP);
  assign o_mdv_valid = disp_ok_s & (i_grp == GRP_MULDIV);
  assign o_agu_valid = disp_ok_s & (i_grp == GRP_AGU);

  assign o_illegal_evt = rst_n & i_valid & i_illegal & ~i_flush;
  assign i_ready = (o_alu_valid & i_alu_ready) | (o_bjp_valid & i_bjp_ready) |
                   (o_mdv_valid & i_mdv_ready) | (o_agu_valid & i_agu_ready) |
                   o_illegal_evt;

  assign alloc_s     = ((o_mdv_valid & i_mdv_ready) |
                        (o_agu_valid & i_agu_ready & i_load)) & i_rdwen;
  assign retire_s    = i_ret_valid & ~empty_s;
  assign stall_inc_s = rst_n & i_valid & ~i_illegal & ~i_flush & block_s;

  assign o_disp_ptr   = wr_ptr_r[PTR_W-1:0];
  assign o_oitf_empty = empty_s;

  // OITF storage and pointers; alloc and retire never target the same slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_vld_r <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
        ent_idx_r[i] <= '0;
      end
    end else begin
      if (retire_s) begin
        ent_vld_r[rd_ptr_r[PTR_W-1:0]] <= 1'b0;
        rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (alloc_s) begin
        ent_vld_r[wr_ptr_r[PTR_W-1:0]] <= 1'b1;
        ent_idx_r[wr_ptr_r[PTR_W-1:0]] <= i_rdidx;
        wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
    end
  end

  // Sticky retire-underflow flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_oitf_err  <= 1'b0;
      o_stall_cnt <= 32'd0;
    end else begin
      if (i_ret_valid && empty_s) begin
        o_oitf_err <= 1'b1;
      end else begin
        o_oitf_err <= o_oitf_err;
      end
      if (stall_inc_s && (o_stall_cnt != 32'hFFFF_FFFF)) begin
        o_stall_cnt <= o_stall_cnt + 32'd1;
      end else begin
        o_stall_cnt <= o_stall_cnt;
      end
    end
  end

endmodule

// File: tb/tb_exu_dispatch.sv
// Directed bench for exu_dispatch: hand-computed expectations checked with
// immediate assertions; inputs change 1 time unit after each rising edge.
module tb_exu_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid, i_ready;
  logic [1:0]  i_grp;
  logic        i_load, i_illegal, i_rs1en, i_rs2en, i_rdwen;
  logic [4:0]  i_rs1idx, i_rs2idx, i_rdidx;
  logic        i_flush;
  logic        o_alu_valid, i_alu_ready, o_bjp_valid, i_bjp_ready;
  logic        o_mdv_valid, i_mdv_ready, o_agu_valid, i_agu_ready;
  logic [0:0]  o_disp_ptr;
  logic        i_ret_valid, o_oitf_empty, o_illegal_evt, o_oitf_err;
  logic [31:0] o_stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  exu_dispatch dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_grp(i_grp),
    .i_load(i_load), .i_illegal(i_illegal), .i_rs1en(i_rs1en), .i_rs2en(i_rs2en),
    .i_rdwen(i_rdwen), .i_rs1idx(i_rs1idx), .i_rs2idx(i_rs2idx), .i_rdidx(i_rdidx),
    .i_flush(i_flush), .o_alu_valid(o_alu_valid), .i_alu_ready(i_alu_ready),
    .o_bjp_valid(o_bjp_valid), .i_bjp_ready(i_bjp_ready), .o_mdv_valid(o_mdv_valid),
    .i_mdv_ready(i_mdv_ready), .o_agu_valid(o_agu_valid), .i_agu_ready(i_agu_ready),
    .o_disp_ptr(o_disp_ptr), .i_ret_valid(i_ret_valid), .o_oitf_empty(o_oitf_empty),
    .o_illegal_evt(o_illegal_evt), .o_oitf_err(o_oitf_err), .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0; i_grp = 2'd0; i_load = 1'b0; i_illegal = 1'b0;
    i_rs1en = 1'b0; i_rs2en = 1'b0; i_rdwen = 1'b0;
    i_rs1idx = 5'd0; i_rs2idx = 5'd0; i_rdidx = 5'd0;
    i_flush = 1'b0; i_ret_valid = 1'b0;
  endtask

  task automatic instr(input logic [1:0] grp, input logic ld,
                       input logic r1en, input logic [4:0] r1,
                       input logic r2en, input logic [4:0] r2,
                       input logic rdw, input logic [4:0] rd);
    i_valid = 1'b1; i_illegal = 1'b0; i_grp = grp; i_load = ld;
    i_rs1en = r1en; i_rs1idx = r1; i_rs2en = r2en; i_rs2idx = r2;
    i_rdwen = rdw; i_rdidx = rd;
  endtask

  task automatic units(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, o_alu_valid, o_bjp_valid, o_mdv_valid, o_agu_valid}, {28'd0, exp});
  endtask

  initial begin
    idle();
    i_alu_ready = 1'b1; i_bjp_ready = 1'b1; i_mdv_ready = 1'b1; i_agu_ready = 1'b1;

    // Reset: outputs gated even with an instruction offered
    instr(2'd0, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5);
    #2;
    units("rst_units", 4'b0000);
    chk("rst_ready", {31'd0, i_ready}, 32'd0);
    tick(); tick();
    rst_n = 1'b1; idle();
    #1;
    chk("rst_empty", {31'd0, o_oitf_empty}, 32'd1);
    chk("rst_stall", o_stall_cnt, 32'd0);
    chk("rst_err", {31'd0, o_oitf_err}, 32'd0);
    chk("rst_ptr", {31'd0, o_disp_ptr}, 32'd0);

    // 1: ALU add rd=x5
    instr(2'd0, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5);
    #1;
    units("alu_units", 4'b1000);
    chk("alu_ready", {31'd0, i_ready}, 32'd1);
    tick(); idle(); #1;
    chk("alu_empty", {31'd0, o_oitf_empty}, 32'd1);

    // 2: MULDIV rd=x3 then dependent ALU stalls until retire
    instr(2'd2, 1'b0, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd3);
    #1;
    units("mdv_units", 4'b0010);
    chk("mdv_ready", {31'd0, i_ready}, 32'd1);
    chk("mdv_ptr", {31'd0, o_disp_ptr}, 32'd0);
    tick();
    instr(2'd0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd7);
    #1;
    chk("raw_notempty", {31'd0, o_oitf_empty}, 32'd0);
    units("raw_units", 4'b0000);
    chk("raw_ready", {31'd0, i_ready}, 32'd0);
    tick();
    chk("raw_stall1", o_stall_cnt, 32'd1);
    tick();
    chk("raw_stall2", o_stall_cnt, 32'd2);
    i_ret_valid = 1'b1;
    #1;
    units("raw_ret_units", 4'b0000);
    tick();
    i_ret_valid = 1'b0;
    #1;
    chk("raw_stall3", o_stall_cnt, 32'd3);
    chk("raw_ret_empty", {31'd0, o_oitf_empty}, 32'd1);
    units("raw_go_units", 4'b1000);
    chk("raw_go_ready", {31'd0, i_ready}, 32'd1);
    tick(); idle(); #1;
    chk("raw_stall_hold", o_stall_cnt, 32'd3);

    // Fresh reset so the load slots start at 0
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    chk("rst2_stall", o_stall_cnt, 32'd0);

    // 3: two loads fill the OITF, third stalls, retire+alloc is blocked
    instr(2'd3, 1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd1);
    #1;
    units("ld1_units", 4'b0001);
    chk("ld1_ptr", {31'd0, o_disp_ptr}, 32'd0);
    tick();
    instr(2'd3, 1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd2);
    #1;
    units("ld2_units", 4'b0001);
    chk("ld2_ptr", {31'd0, o_disp_ptr}, 32'd1);
    tick();
    instr(2'd3, 1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd4);
    #1;
    units("ld3_full_units", 4'b0000);
    chk("ld3_full_ready", {31'd0, i_ready}, 32'd0);
    tick();
    chk("ld3_stall1", o_stall_cnt, 32'd1);
    i_ret_valid = 1'b1;
    #1;
    units("ld3_retfull_units", 4'b0000);
    tick();
    i_ret_valid = 1'b0;
    #1;
    chk("ld3_stall2", o_stall_cnt, 32'd2);
    units("ld3_wrap_units", 4'b0001);
    chk("ld3_wrap_ptr", {31'd0, o_disp_ptr}, 32'd0);
    tick();
    // OITF now holds x2 (slot1) and x4 (slot0) and is full
    instr(2'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b1, 5'd9);
    #1;
    units("raw_rs2_units", 4'b0000);
    instr(2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4);
    #1;
    units("waw_units", 4'b0000);
    instr(2'd0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 5'd7);
    #1;
    units("full_alu_units", 4'b1000);
    instr(2'd3, 1'b0, 1'b1, 5'd9, 1'b1, 5'd8, 1'b0, 5'd0);
    #1;
    units("full_store_units", 4'b0001);
    instr(2'd1, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    units("bjp_raw_units", 4'b0000);
    instr(2'd1, 1'b0, 1'b1, 5'd11, 1'b0, 5'd0, 1'b1, 5'd1);
    #1;
    units("bjp_units", 4'b0100);

    // 4: illegal consumed without dispatch or allocation
    instr(2'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12);
    i_illegal = 1'b1;
    #1;
    units("ill_units", 4'b0000);
    chk("ill_ready", {31'd0, i_ready}, 32'd1);
    chk("ill_evt", {31'd0, o_illegal_evt}, 32'd1);
    tick();
    idle(); #1;
    chk("ill_evt_drop", {31'd0, o_illegal_evt}, 32'd0);
    chk("ill_ptr", {31'd0, o_disp_ptr}, 32'd1);
    chk("ill_stall", o_stall_cnt, 32'd2);

    // Flush suppresses dispatch, illegal event and stall counting
    instr(2'd0, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 5'd7);
    i_flush = 1'b1;
    #1;
    units("flush_units", 4'b0000);
    chk("flush_ready", {31'd0, i_ready}, 32'd0);
    tick();
    i_illegal = 1'b1;
    #1;
    chk("flush_ill_evt", {31'd0, o_illegal_evt}, 32'd0);
    idle(); #1;
    chk("flush_stall", o_stall_cnt, 32'd2);

    // 5: drain, then retire while empty sets the sticky error
    i_ret_valid = 1'b1;
    tick(); tick();
    chk("drain_empty", {31'd0, o_oitf_empty}, 32'd1);
    tick();
    i_ret_valid = 1'b0;
    #1;
    chk("err_set", {31'd0, o_oitf_err}, 32'd1);
    chk("err_ptr", {31'd0, o_disp_ptr}, 32'd1);
    chk("err_empty", {31'd0, o_oitf_empty}, 32'd1);
    tick();
    chk("err_sticky", {31'd0, o_oitf_err}, 32'd1);

    // 6: two pending MULDIVs, then reset clears everything
    instr(2'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8);
    #1;
    chk("m1_ptr", {31'd0, o_disp_ptr}, 32'd1);
    units("m1_units", 4'b0010);
    tick();
    instr(2'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
    #1;
    chk("m2_ptr", {31'd0, o_disp_ptr}, 32'd0);
    tick();
    rst_n = 1'b0;
    #1;
    units("rst3_units", 4'b0000);
    chk("rst3_ready", {31'd0, i_ready}, 32'd0);
    chk("rst3_pending", {31'd0, o_oitf_empty}, 32'd0);
    tick();
    rst_n = 1'b1; idle(); #1;
    chk("rst3_empty", {31'd0, o_oitf_empty}, 32'd1);
    chk("rst3_stall", o_stall_cnt, 32'd0);
    chk("rst3_err", {31'd0, o_oitf_err}, 32'd0);
    chk("rst3_ptr", {31'd0, o_disp_ptr}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
